// File: rtl/spi_slave.sv
// SPI mode-0 slave (CPOL=0, CPHA=0, MSB first) oversampled on the system clock,
// with a single-entry transmit holding buffer and a one-cycle receive strobe.
module spi_slave #(
    parameter int                DATA_W      = 8,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] IDLE_BYTE   = 8'hFF
) (
    input  logic              sclk,
    input  logic              rst_n,
    input  logic              SPI_SCLK,
    input  logic              SPI_CSN,
    input  logic              SPI_MOSI,
    output logic              SPI_MISO,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] tx_wr_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_rd_data,
    output logic              rx_valid,
    output logic              tx_underrun,
    output logic              busy
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    logic [SYNC_STAGES-1:0] r_sclkSync;
    logic [SYNC_STAGES-1:0] r_csnSync;
    logic [SYNC_STAGES-1:0] r_mosiSync;
    logic                   r_sclkPrev;
    logic                   r_csnPrev;

    state_t            r_state;
    logic [CNT_W-1:0]  r_bitCnt;
    logic [DATA_W-1:0] r_txShift;
    logic [DATA_W-1:0] r_rxShift;
    logic [DATA_W-1:0] r_rxData;
    logic [DATA_W-1:0] r_buf;
    logic              r_bufFull;
    logic              r_rxDone;
    logic              r_rxValid;
    logic              r_txUnderrun;
    logic              r_miso;
    logic              r_misoOe;
    logic              r_busy;

    logic              w_sclk;
    logic              w_csn;
    logic              w_mosi;
    logic              w_sclkRise;
    logic              w_sclkFall;
    logic              w_csnFall;
    logic              w_csnRise;
    logic              w_load;
    logic              w_write;
    logic [DATA_W-1:0] w_loadByte;

    // Synchronizers reset to the bus idle levels so reset release never looks like an edge.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclkSync <= '0;
            r_csnSync  <= '1;
            r_mosiSync <= '0;
            r_sclkPrev <= 1'b0;
            r_csnPrev  <= 1'b1;
        end else begin
            r_sclkSync <= {r_sclkSync[SYNC_STAGES-2:0], SPI_SCLK};
            r_csnSync  <= {r_csnSync[SYNC_STAGES-2:0], SPI_CSN};
            r_mosiSync <= {r_mosiSync[SYNC_STAGES-2:0], SPI_MOSI};
            r_sclkPrev <= w_sclk;
            r_csnPrev  <= w_csn;
        end
    end

    assign w_sclk     = r_sclkSync[SYNC_STAGES-1];
    assign w_csn      = r_csnSync[SYNC_STAGES-1];
    assign w_mosi     = r_mosiSync[SYNC_STAGES-1];
    assign w_sclkRise = w_sclk & ~r_sclkPrev;
    assign w_sclkFall = ~w_sclk & r_sclkPrev;
    assign w_csnFall  = ~w_csn & r_csnPrev;
    assign w_csnRise  = w_csn & ~r_csnPrev;

    // A load samples the buffer before any same-cycle write lands in it.
    assign w_load     = ((r_state == IDLE) && w_csnFall) ||
                        ((r_state == ACTIVE) && !w_csnRise && w_sclkFall && (r_bitCnt == '0));
    assign w_write    = tx_valid && !r_bufFull;
    assign w_loadByte = r_bufFull ? r_buf : IDLE_BYTE;

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_bitCnt     <= '0;
            r_txShift    <= '0;
            r_rxShift    <= '0;
            r_rxData     <= '0;
            r_buf        <= '0;
            r_bufFull    <= 1'b0;
            r_rxDone     <= 1'b0;
            r_rxValid    <= 1'b0;
            r_txUnderrun <= 1'b0;
            r_miso       <= 1'b0;
            r_misoOe     <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_rxValid    <= 1'b0;
            r_txUnderrun <= 1'b0;
            r_rxDone     <= 1'b0;

            if (r_rxDone) begin
                r_rxData  <= r_rxShift;
                r_rxValid <= 1'b1;
            end

            if (w_load) begin
                r_txShift    <= w_loadByte;
                r_miso       <= w_loadByte[DATA_W-1];
                r_txUnderrun <= !r_bufFull;
                if (r_bufFull) begin
                    r_bufFull <= 1'b0;
                end
            end

            if (w_write) begin
                r_buf     <= tx_wr_data;
                r_bufFull <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (w_csnFall) begin
                        r_state  <= ACTIVE;
                        r_bitCnt <= '0;
                        r_misoOe <= 1'b1;
                        r_busy   <= 1'b1;
                    end
                end
                ACTIVE: begin
                    // Deselect wins over any SCLK strobe; a partial byte is simply dropped.
                    if (w_csnRise) begin
                        r_state  <= IDLE;
                        r_bitCnt <= '0;
                        r_misoOe <= 1'b0;
                        r_miso   <= 1'b0;
                        r_busy   <= 1'b0;
                    end else begin
                        if (w_sclkRise) begin
                            r_rxShift <= {r_rxShift[DATA_W-2:0], w_mosi};
                            if (r_bitCnt == LAST_BIT) begin
                                r_bitCnt <= '0;
                                r_rxDone <= 1'b1;
                            end else begin
                                r_bitCnt <= r_bitCnt + CNT_W'(1);
                            end
                        end
                        if (w_sclkFall && (r_bitCnt != '0)) begin
                            r_txShift <= {r_txShift[DATA_W-2:0], 1'b0};
                            r_miso    <= r_txShift[DATA_W-2];
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign SPI_MISO    = r_miso;
    assign miso_oe     = r_misoOe;
    assign tx_ready    = !r_bufFull;
    assign rx_rd_data  = r_rxData;
    assign rx_valid    = r_rxValid;
    assign tx_underrun = r_txUnderrun;
    assign busy        = r_busy;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a bit-banged mode-0 master plus a byte-level model of the
// holding buffer and expected receive stream, checked every cycle.
module tb_spi_slave;

    localparam int S = 2;

    logic       sclk       = 1'b0;
    logic       rst_n      = 1'b0;
    logic       SPI_SCLK   = 1'b0;
    logic       SPI_CSN    = 1'b1;
    logic       SPI_MOSI   = 1'b0;
    logic [7:0] tx_wr_data = 8'h00;
    logic       tx_valid   = 1'b0;
    logic       SPI_MISO;
    logic       miso_oe;
    logic       tx_ready;
    logic [7:0] rx_rd_data;
    logic       rx_valid;
    logic       tx_underrun;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    bit         compareEn     = 1'b0;
    bit         modelFull     = 1'b0;
    logic [7:0] modelBuf      = 8'h00;
    logic [7:0] modelLastRx   = 8'h00;
    logic [7:0] expRxQ[$];
    int         expRxCycQ[$];
    int         expUnderruns  = 0;
    int         seenUnderruns = 0;
    int         rxCount       = 0;
    int         csnChangeCycle = 0;
    logic [7:0] frameMosi[4];
    logic [7:0] gotBytes[4];

    spi_slave #(
        .DATA_W(8),
        .SYNC_STAGES(S),
        .IDLE_BYTE(8'hFF)
    ) dut (
        .sclk(sclk),
        .rst_n(rst_n),
        .SPI_SCLK(SPI_SCLK),
        .SPI_CSN(SPI_CSN),
        .SPI_MOSI(SPI_MOSI),
        .SPI_MISO(SPI_MISO),
        .miso_oe(miso_oe),
        .tx_wr_data(tx_wr_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .rx_rd_data(rx_rd_data),
        .rx_valid(rx_valid),
        .tx_underrun(tx_underrun),
        .busy(busy)
    );

    always #5 sclk = ~sclk;

    always @(posedge sclk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // Per-cycle comparison against the byte-level model, sampled mid-cycle.
    always @(negedge sclk) begin
        if (rst_n && compareEn) begin
            if (rx_valid) begin
                rxCount++;
                if (expRxQ.size() == 0) begin
                    checkOutput("rxUnexpected", 1, 0);
                end else begin
                    checkOutput("rxData", rx_rd_data, expRxQ[0]);
                    checkOutput("rxLatency", cycle - expRxCycQ[0], S + 2);
                    modelLastRx = expRxQ.pop_front();
                    void'(expRxCycQ.pop_front());
                end
            end else begin
                checkOutput("rxHold", rx_rd_data, modelLastRx);
            end
            if (cycle - csnChangeCycle >= S + 1) begin
                checkOutput("busy", busy, !SPI_CSN);
                checkOutput("misoOe", miso_oe, !SPI_CSN);
                if (SPI_CSN) checkOutput("misoIdle", SPI_MISO, 0);
            end
            if (tx_underrun) seenUnderruns++;
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge sclk);
        #1;
    endtask

    task automatic modelLoad(output logic [7:0] b);
        if (modelFull) begin
            b = modelBuf;
            modelFull = 1'b0;
        end else begin
            b = 8'hFF;
            expUnderruns++;
        end
    endtask

    task automatic writeByte(input logic [7:0] d);
        checkOutput("txReadyBeforeWrite", tx_ready, !modelFull);
        tx_wr_data = d;
        tx_valid   = 1'b1;
        waitCycles(1);
        tx_valid   = 1'b0;
        modelFull  = 1'b1;
        modelBuf   = d;
        checkOutput("txReadyAfterWrite", tx_ready, 0);
    endtask

    // One master frame: nBytes from frameMosi, cut off after nBits (CSN rises with the last fall).
    task automatic applyStimulus(input int nBytes, input int nBits, input bit midWrite,
                                 input logic [7:0] midData, input bit simWrite,
                                 input logic [7:0] simData, input bit resetAtEnd);
        int         h;
        int         k;
        logic [7:0] expTx[4];
        logic [7:0] got;
        h   = $urandom_range(S + 1, S + 4);
        got = 8'h00;
        SPI_CSN = 1'b0;
        csnChangeCycle = cycle;
        if (simWrite) begin
            waitCycles(S);
            checkOutput("txReadySim", tx_ready, 1);
            tx_wr_data = simData;
            tx_valid   = 1'b1;
            waitCycles(1);
            tx_valid   = 1'b0;
        end
        k = 0;
        for (int b = 0; b < nBytes; b++) begin
            if (k < nBits) begin
                modelLoad(expTx[b]);
                if (simWrite && b == 0) begin
                    modelFull = 1'b1;
                    modelBuf  = simData;
                end
            end
            for (int i = 0; i < 8; i++) begin
                if (k < nBits) begin
                    SPI_MOSI = frameMosi[b][7-i];
                    waitCycles(h);
                    if (k == 0) checkOutput("txReadyAfterLoad", tx_ready, !modelFull);
                    got[7-i] = SPI_MISO;
                    SPI_SCLK = 1'b1;
                    if (i == 7) begin
                        expRxQ.push_back(frameMosi[b]);
                        expRxCycQ.push_back(cycle);
                    end
                    if (midWrite && b == 0 && i == 3 && !modelFull) writeByte(midData);
                    waitCycles(h);
                    SPI_SCLK = 1'b0;
                    if (k == nBits - 1 && !resetAtEnd) begin
                        SPI_CSN = 1'b1;
                        csnChangeCycle = cycle;
                    end
                    k++;
                end
            end
            if (k == (b + 1) * 8) begin
                gotBytes[b] = got;
                checkOutput("misoByte", got, expTx[b]);
            end
        end
        if (resetAtEnd) begin
            rst_n    = 1'b0;
            SPI_CSN  = 1'b1;
            SPI_MOSI = 1'b0;
            csnChangeCycle = cycle;
            #1;
            checkOutput("rstMiso", SPI_MISO, 0);
            checkOutput("rstMisoOe", miso_oe, 0);
            checkOutput("rstTxReady", tx_ready, 1);
            checkOutput("rstRxData", rx_rd_data, 0);
            checkOutput("rstRxValid", rx_valid, 0);
            checkOutput("rstUnderrun", tx_underrun, 0);
            checkOutput("rstBusy", busy, 0);
            expRxQ.delete();
            expRxCycQ.delete();
            modelFull   = 1'b0;
            modelLastRx = 8'h00;
            waitCycles(2);
            rst_n = 1'b1;
        end
        waitCycles(S + 6);
        checkOutput("rxPending", expRxQ.size(), 0);
        checkOutput("underruns", seenUnderruns, expUnderruns);
        checkOutput("txReadyIdle", tx_ready, !modelFull);
    endtask

    initial begin
        int u0;
        int r0;
        int nb;
        int nBits;
        waitCycles(3);
        checkOutput("resetMiso", SPI_MISO, 0);
        checkOutput("resetMisoOe", miso_oe, 0);
        checkOutput("resetTxReady", tx_ready, 1);
        checkOutput("resetRxData", rx_rd_data, 0);
        checkOutput("resetRxValid", rx_valid, 0);
        checkOutput("resetUnderrun", tx_underrun, 0);
        checkOutput("resetBusy", busy, 0);
        rst_n = 1'b1;
        csnChangeCycle = cycle;
        compareEn = 1'b1;
        waitCycles(5);

        // Reset mid-frame, then a clean frame.
        frameMosi[0] = 8'($urandom);
        applyStimulus(1, 3, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        writeByte(8'h5A);
        frameMosi[0] = 8'hC3;
        applyStimulus(1, 8, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        checkOutput("t1Rx", rx_rd_data, 8'hC3);
        checkOutput("t1Miso", gotBytes[0], 8'h5A);

        // Single byte.
        writeByte(8'h3C);
        frameMosi[0] = 8'hA5;
        r0 = rxCount;
        applyStimulus(1, 8, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        checkOutput("t2Rx", rx_rd_data, 8'hA5);
        checkOutput("t2Miso", gotBytes[0], 8'h3C);
        checkOutput("t2RxCount", rxCount - r0, 1);

        // Back-to-back with refill during byte 1.
        writeByte(8'h11);
        frameMosi[0] = 8'hDE;
        frameMosi[1] = 8'hAD;
        u0 = seenUnderruns;
        r0 = rxCount;
        applyStimulus(2, 16, 1'b1, 8'h22, 1'b0, 8'h00, 1'b0);
        checkOutput("t3Miso0", gotBytes[0], 8'h11);
        checkOutput("t3Miso1", gotBytes[1], 8'h22);
        checkOutput("t3Underruns", seenUnderruns - u0, 0);
        checkOutput("t3RxCount", rxCount - r0, 2);
        checkOutput("t3Rx", rx_rd_data, 8'hAD);

        // Underrun.
        frameMosi[0] = 8'h96;
        u0 = seenUnderruns;
        r0 = rxCount;
        applyStimulus(1, 8, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        checkOutput("t4Miso", gotBytes[0], 8'hFF);
        checkOutput("t4Underruns", seenUnderruns - u0, 1);
        checkOutput("t4Rx", rx_rd_data, 8'h96);
        checkOutput("t4RxCount", rxCount - r0, 1);

        // Abort after 5 bits, then a full frame.
        frameMosi[0] = 8'h5F;
        r0 = rxCount;
        applyStimulus(1, 5, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        checkOutput("t5RxCount", rxCount - r0, 0);
        checkOutput("t5Busy", busy, 0);
        checkOutput("t5MisoOe", miso_oe, 0);
        checkOutput("t5RxHeld", rx_rd_data, 8'h96);
        frameMosi[0] = 8'h81;
        applyStimulus(1, 8, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        checkOutput("t5Rx", rx_rd_data, 8'h81);

        // Write coinciding with the CSN-fall load.
        frameMosi[0] = 8'h3A;
        frameMosi[1] = 8'hC5;
        u0 = seenUnderruns;
        applyStimulus(2, 16, 1'b0, 8'h00, 1'b1, 8'h77, 1'b0);
        checkOutput("t6Miso0", gotBytes[0], 8'hFF);
        checkOutput("t6Miso1", gotBytes[1], 8'h77);
        checkOutput("t6Underruns", seenUnderruns - u0, 1);

        // Randomized frames, including occasional aborts.
        for (int f = 0; f < 20; f++) begin
            nb = $urandom_range(1, 3);
            for (int b = 0; b < 4; b++) frameMosi[b] = 8'($urandom);
            if (!modelFull && ($urandom_range(0, 1) == 1)) writeByte(8'($urandom));
            nBits = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, nb * 8 - 1)) : nb * 8;
            applyStimulus(nb, nBits, 1'($urandom_range(0, 1)), 8'($urandom), 1'b0, 8'h00, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
